// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyph table, decode status.
// Pure constants, no latency; no flow control.
// Encoder and decoder both reference GLYPH_TBL so the two sides cannot drift apart.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Index is the nibble value; bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] GLYPH_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        DEC_OK    = 2'd0,
        DEC_BLANK = 2'd1,
        DEC_BAD   = 2'd2
    } decode_status_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Segment pattern to hex nibble lookup with legality status.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input pattern.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [NIB_W-1:0] nib,
    output decode_status_t   status
);

    always_comb begin
        nib    = '0;
        status = (seg == SEG_BLANK) ? DEC_BLANK : DEC_BAD;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH_TBL[i]) begin
                nib    = NIB_W'(i);
                status = DEC_OK;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex nibbles from a multiplexed seven-segment bus after a stable run.
// Latency: pattern at pins before edge T gives update in cycle T+STABLE_CYCLES+2.
// Backpressure: none; bus is sampled every cycle, short glitches are filtered by the run length.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter bit ACTIVE_LOW    = 1'b0,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic [IW-1:0]           update_idx
);

    localparam int         VW      = NUM_DIGITS + SEG_W;
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    logic [VW-1:0]         raw_vec;
    logic [VW-1:0]         sync1;
    logic [VW-1:0]         sync2;
    logic [VW-1:0]         prev;
    logic [7:0]            run_len;
    logic [7:0]            run_nxt;
    logic                  commit;
    logic [SEG_W-1:0]      commit_seg;
    logic [NUM_DIGITS-1:0] commit_dig;
    logic                  sel_ok;
    logic [IW-1:0]         sel_idx;
    logic [NIB_W-1:0]      dec_nib;
    decode_status_t        dec_status;

    assign raw_vec = ACTIVE_LOW ? ~{dig_sel, seg_in} : {dig_sel, seg_in};

    always_comb begin
        run_nxt = run_len;
        if (sync2 != prev) begin
            run_nxt = 8'd1;
        end else if (run_len != RUN_MAX) begin
            run_nxt = run_len + 8'd1;
        end
    end

    // commit is high in the cycle after the run reaches its limit, so prev holds the counted pattern
    assign commit_seg = prev[SEG_W-1:0];
    assign commit_dig = prev[VW-1:SEG_W];
    assign sel_ok     = (commit_dig != '0) &&
                        ((commit_dig & (commit_dig - NUM_DIGITS'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit_dig[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    seg7_to_hex u_to_hex (
        .seg    (commit_seg),
        .nib    (dec_nib),
        .status (dec_status)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            run_len     <= '0;
            commit      <= 1'b0;
            digits_out  <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            update      <= 1'b0;
            update_idx  <= '0;
        end else begin
            sync1   <= raw_vec;
            sync2   <= sync1;
            prev    <= sync2;
            run_len <= run_nxt;
            commit  <= (run_nxt == RUN_MAX) && (run_len != RUN_MAX);
            update  <= 1'b0;
            if (commit && sel_ok) begin
                update     <= 1'b1;
                update_idx <= sel_idx;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (commit_dig[i]) begin
                        case (dec_status)
                            DEC_OK: begin
                                digits_out[4*i +: 4] <= dec_nib;
                                digit_valid[i]       <= 1'b1;
                                digit_err[i]         <= 1'b0;
                            end
                            DEC_BLANK: begin
                                digit_valid[i] <= 1'b0;
                                digit_err[i]   <= 1'b0;
                            end
                            default: begin
                                digit_valid[i] <= 1'b0;
                                digit_err[i]   <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized scan traffic
// compared every cycle against an event-level reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam bit AL = 1'b1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg_in = '0;
    logic [ND-1:0]   dig_sel = '0;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   digit_err;
    logic            update;
    logic [1:0]      update_idx;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (AL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update),
        .update_idx  (update_idx)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

    int n_chk  = 0;
    int n_fail = 0;
    int upd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          at;
        logic [10:0] v;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    int          edge_no = 0;
    logic [10:0] lv;
    logic [10:0] m_s1 = '0;
    logic [10:0] m_run_val = '0;
    logic [10:0] arriving;
    int          m_cnt = 0;
    logic [15:0] e_dig = '0;
    logic [3:0]  e_vld = '0;
    logic [3:0]  e_err = '0;
    logic        e_upd = 1'b0;
    logic [1:0]  e_idx = '0;

    task automatic model_commit(input logic [10:0] v);
        logic [3:0] d;
        logic [6:0] s;
        int         hits;
        int         idx;
        int         nib;
        d = v[10:7];
        s = v[6:0];
        hits = 0;
        idx = 0;
        for (int i = 0; i < ND; i++) if (d[i]) begin hits++; idx = i; end
        if (hits == 1) begin
            e_upd = 1'b1;
            e_idx = 2'(idx);
            nib = -1;
            for (int g = 0; g < 16; g++) if (tbl[g] == s) nib = g;
            if (nib >= 0) begin
                e_dig[4*idx +: 4] = 4'(nib);
                e_vld[idx] = 1'b1;
                e_err[idx] = 1'b0;
            end else begin
                e_vld[idx] = 1'b0;
                e_err[idx] = (s != 7'h00);
            end
        end
    endtask

    always @(posedge clk) begin
        edge_no++;
        lv = AL ? ~{dig_sel, seg_in} : {dig_sel, seg_in};
        if (!rst_n) begin
            m_s1 = '0;
            m_run_val = '0;
            m_cnt = 1;
            evq.delete();
            e_dig = '0;
            e_vld = '0;
            e_err = '0;
            e_upd = 1'b0;
            e_idx = '0;
        end else begin
            e_upd = 1'b0;
            if (evq.size() > 0 && evq[0].at == edge_no) begin
                ev = evq.pop_front();
                model_commit(ev.v);
            end
            // Value reaching the sampled stage this edge after the two-stage synchroniser
            arriving = m_s1;
            m_s1 = lv;
            if (arriving == m_run_val) begin
                if (m_cnt < SC) begin
                    m_cnt++;
                    if (m_cnt == SC) evq.push_back('{edge_no + 2, arriving});
                end
            end else begin
                m_run_val = arriving;
                m_cnt = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
        chk("digits_out", 32'(digits_out), 32'(e_dig));
        chk("digit_valid", 32'(digit_valid), 32'(e_vld));
        chk("digit_err", 32'(digit_err), 32'(e_err));
        chk("update", 32'(update), 32'(e_upd));
        if (e_upd) chk("update_idx", 32'(update_idx), 32'(e_idx));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        {dig_sel, seg_in} = AL ? ~{d, s} : {d, s};
        repeat (n) @(negedge clk);
    endtask

    int u0;
    logic [3:0] rd;
    logic [6:0] rs;
    int sel;

    initial begin
        @(negedge clk);
        // reset held with a legal pattern on the bus
        rst_n = 1'b0;
        drive(4'b0001, 7'h7F, 20);
        #1;
        chk("rst_upd", 32'(upd_cnt), 32'd0);
        chk("rst_digits", 32'(digits_out), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        @(negedge clk);
        drive(4'b0000, 7'h00, 2);
        rst_n = 1'b1;
        drive(4'b0000, 7'h00, 12);

        // directed decode on digit 1
        u0 = upd_cnt;
        drive(4'b0010, 7'h5B, 60);
        #1;
        chk("dir_upd", 32'(upd_cnt - u0), 32'd1);
        chk("dir_nib", 32'(digits_out[7:4]), 32'h2);
        chk("dir_valid", 32'(digit_valid), 32'b0010);
        chk("dir_err", 32'(digit_err), 32'b0000);

        // glitch shorter than the run length is ignored
        @(negedge clk);
        u0 = upd_cnt;
        drive(4'b0001, 7'h06, 5);
        drive(4'b0001, 7'h4F, 30);
        #1;
        chk("glitch_upd", 32'(upd_cnt - u0), 32'd1);
        chk("glitch_nib", 32'(digits_out[3:0]), 32'h3);

        // illegal pattern keeps the nibble, blank clears the error
        @(negedge clk);
        u0 = upd_cnt;
        drive(4'b1000, 7'h79, 30);
        drive(4'b1000, 7'h01, 30);
        #1;
        chk("bad_err", 32'(digit_err[3]), 32'd1);
        chk("bad_valid", 32'(digit_valid[3]), 32'd0);
        chk("bad_nib", 32'(digits_out[15:12]), 32'hE);
        @(negedge clk);
        drive(4'b1000, 7'h00, 30);
        #1;
        chk("blank_err", 32'(digit_err[3]), 32'd0);
        chk("blank_valid", 32'(digit_valid[3]), 32'd0);
        chk("blank_upd", 32'(upd_cnt - u0), 32'd3);

        // non-one-hot selects never commit
        @(negedge clk);
        u0 = upd_cnt;
        drive(4'b0000, 7'h3F, 30);
        drive(4'b0110, 7'h3F, 30);
        #1;
        chk("badsel_upd", 32'(upd_cnt - u0), 32'd0);
        chk("badsel_digits", 32'(digits_out), 32'hE023);
        chk("badsel_valid", 32'(digit_valid), 32'b0011);

        // sweep all glyphs across the four digits
        @(negedge clk);
        u0 = upd_cnt;
        for (int g = 0; g < 16; g++) drive(4'(1 << (g % 4)), tbl[g], 10);
        drive(4'b0000, 7'h00, 5);
        #1;
        chk("sweep_upd", 32'(upd_cnt - u0), 32'd16);
        chk("sweep_digits", 32'(digits_out), 32'hFEDC);
        chk("sweep_valid", 32'(digit_valid), 32'hF);

        // reset in the middle of a window
        @(negedge clk);
        u0 = upd_cnt;
        drive(4'b0001, 7'h06, 4);
        rst_n = 1'b0;
        drive(4'b0001, 7'h06, 2);
        #1;
        chk("midrst_digits", 32'(digits_out), 32'd0);
        chk("midrst_valid", 32'(digit_valid), 32'd0);
        @(negedge clk);
        drive(4'b0000, 7'h00, 1);
        rst_n = 1'b1;
        drive(4'b0000, 7'h00, 12);
        #1;
        chk("midrst_upd", 32'(upd_cnt - u0), 32'd0);

        // randomized scan traffic against the model
        @(negedge clk);
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6) rs = tbl[$urandom_range(0, 15)];
            else if (sel == 7) rs = 7'h00;
            else rs = 7'($urandom_range(0, 127));
            sel = $urandom_range(0, 7);
            if (sel < 6) rd = 4'(1 << $urandom_range(0, 3));
            else if (sel == 6) rd = 4'b0000;
            else rd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                drive(rd, rs, $urandom_range(1, 3));
                rst_n = 1'b1;
            end
            drive(rd, rs, $urandom_range(1, 14));
        end
        drive(4'b0000, 7'h00, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
